// File: rtl/conv_window_gen_if.sv
// Pixel-stream in / 3x3-window out bundle for conv_window_gen.
// slave = window generator, master = pixel source and window consumer.
interface conv_window_gen_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0]             pixel_i;
    logic                               pixel_valid_i;
    logic                               sof_i;
    logic [2:0][2:0][PIXEL_WIDTH-1:0]   window_o;
    logic                               window_valid_o;
    logic                               frame_done_o;
    logic                               frame_err_o;

    modport master (
        output pixel_i, pixel_valid_i, sof_i,
        input  window_o, window_valid_o, frame_done_o, frame_err_o
    );

    modport slave (
        input  pixel_i, pixel_valid_i, sof_i,
        output window_o, window_valid_o, frame_done_o, frame_err_o
    );
endinterface

// File: rtl/conv_window_gen.sv
// Raster-scan pixel stream to 3x3 sliding-window generator using two line buffers.
// Optional macro SOF_CHECK_EN: frames start only on sof_i; sof_i mid-frame aborts and restarts.
module conv_window_gen #(
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28,
    parameter int PIXEL_WIDTH = 8
) (
    input logic              clk_i,
    input logic              rst_ni,
    conv_window_gen_if.slave pix_if
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {IDLE, FILL, ACTIVE} state_t;
    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, cur_col;
    logic [RW-1:0] row_q, cur_row;
    logic          sof_ok, restart, take;
    logic          row_end, frame_end, win_ok;

    pixel_t        lb0_q [IMG_WIDTH];   // row r-1
    pixel_t        lb1_q [IMG_WIDTH];   // row r-2
    logic [2:0][2:0][PIXEL_WIDTH-1:0] window_q;
    logic          window_valid_q, frame_done_q, frame_err_q;

`ifdef SOF_CHECK_EN
    assign sof_ok  = pix_if.sof_i;
    assign restart = pix_if.pixel_valid_i && pix_if.sof_i && (state_q != IDLE);
`else
    assign sof_ok  = 1'b1;
    assign restart = 1'b0;
`endif

    // An aborting sof pixel is treated as (0,0) of the new frame.
    assign take      = pix_if.pixel_valid_i && ((state_q != IDLE) || sof_ok);
    assign cur_col   = restart ? '0 : col_q;
    assign cur_row   = restart ? '0 : row_q;
    assign row_end   = (cur_col == COL_LAST);
    assign frame_end = row_end && (cur_row == ROW_LAST);
    assign win_ok    = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take) state_d = FILL;
            FILL:    if (take && row_end && (cur_row == ROW_ONE)) state_d = ACTIVE;
            ACTIVE: begin
                if (restart)                state_d = FILL;
                else if (take && frame_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            window_valid_q <= take && win_ok;
            frame_done_q   <= take && frame_end;
            frame_err_q    <= restart;
            if (take) begin
                if (row_end) begin
                    col_q <= '0;
                    row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_ONE;
                end else begin
                    col_q <= cur_col + COL_ONE;
                    row_q <= cur_row;
                end
            end
        end
    end

    // NOTE: line buffers are reset explicitly because the reset state defines them as zero;
    // drop the reset branch only if that requirement goes away (saves a reset fan-out).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            window_q <= '0;
            for (int i = 0; i < IMG_WIDTH; i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
        end else if (take) begin
            for (int r = 0; r < 3; r++) begin
                window_q[r][0] <= window_q[r][1];
                window_q[r][1] <= window_q[r][2];
            end
            window_q[0][2] <= lb1_q[cur_col];
            window_q[1][2] <= lb0_q[cur_col];
            window_q[2][2] <= pix_if.pixel_i;
            lb1_q[cur_col] <= lb0_q[cur_col];
            lb0_q[cur_col] <= pix_if.pixel_i;
        end
    end

    assign pix_if.window_o       = window_q;
    assign pix_if.window_valid_o = window_valid_q;
    assign pix_if.frame_done_o   = frame_done_q;
    assign pix_if.frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 4x4 image; pixel value = base + raster index.
// Build with +define+SOF_CHECK_EN to also exercise the sof abort / idle-ignore behaviour.
module tb_conv_window_gen;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;

    typedef logic [2:0][2:0][PW-1:0] win_t;
    typedef struct {
        win_t win;
        int   due;
    } exp_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   cyc    = 0;

    conv_window_gen_if #(.PIXEL_WIDTH(PW)) pix_if ();

    conv_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PIXEL_WIDTH(PW)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .pix_if(pix_if)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    exp_t win_q[$];
    int   done_q[$];
    int   err_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic win_t exp_win(input int base, input int r, input int c);
        win_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = PW'(base + (r - 2 + i) * W + (c - 2 + j));
        return w;
    endfunction

    // Inputs change 1 time unit after a rising edge and are taken on the next one.
    task automatic drive(input logic [PW-1:0] v, input logic s, input logic vld);
        @(posedge clk_i);
        #1;
        pix_if.pixel_i       = v;
        pix_if.sof_i         = s;
        pix_if.pixel_valid_i = vld;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int base, input int n_pix, input int gap_pct, input bit exp_err);
        int r, c;
        for (int k = 0; k < n_pix; k++) begin
            while ($urandom_range(99) < gap_pct) drive('0, 1'b0, 1'b0);
            drive(PW'(base + k), (k == 0), 1'b1);
            r = k / W;
            c = k % W;
            if (k == 0 && exp_err) err_q.push_back(cyc + 1);
            if (r >= 2 && c >= 2) win_q.push_back('{win: exp_win(base, r, c), due: cyc + 1});
            if (k == W * H - 1) done_q.push_back(cyc + 1);
        end
    endtask

    always @(negedge clk_i) begin
        if (win_q.size() > 0 && win_q[0].due < cyc) begin
            mon_e = win_q.pop_front();
            check("win_missing", cyc, mon_e.due);
        end
        if (pix_if.window_valid_o) begin
            if (win_q.size() == 0) check("win_spurious", pix_if.window_valid_o, 1'b0);
            else begin
                mon_e = win_q.pop_front();
                check("win_cycle", cyc, mon_e.due);
                check("win_data", pix_if.window_o, mon_e.win);
            end
        end
        if (done_q.size() > 0 && done_q[0] < cyc) check("done_missing", cyc, done_q.pop_front());
        if (pix_if.frame_done_o) begin
            if (done_q.size() == 0) check("done_spurious", pix_if.frame_done_o, 1'b0);
            else check("done_cycle", cyc, done_q.pop_front());
        end
        if (err_q.size() > 0 && err_q[0] < cyc) check("err_missing", cyc, err_q.pop_front());
        if (pix_if.frame_err_o) begin
            if (err_q.size() == 0) check("err_spurious", pix_if.frame_err_o, 1'b0);
            else check("err_cycle", cyc, err_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        pix_if.pixel_i       = '0;
        pix_if.sof_i         = 1'b0;
        pix_if.pixel_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_window", pix_if.window_o, '0);
        check("rst_valid", pix_if.window_valid_o, 1'b0);
        check("rst_done", pix_if.frame_done_o, 1'b0);
        check("rst_err", pix_if.frame_err_o, 1'b0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // T1: continuous frame; window holds last value afterwards
        send_frame(0, W * H, 0, 1'b0);
        idle(4);
        check("hold_window_t1", pix_if.window_o, exp_win(0, 3, 3));

        // T2: random gaps
        send_frame(0, W * H, 50, 1'b0);
        idle(4);

        // T3: back-to-back frames, zero bubble
        send_frame(0, W * H, 0, 1'b0);
        send_frame(100, W * H, 0, 1'b0);
        idle(4);
        check("hold_window_t3", pix_if.window_o, exp_win(100, 3, 3));

        // T4: reset after pixel 9, then a full frame
        send_frame(0, 10, 0, 1'b0);
        drive('0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("t4_rst_window", pix_if.window_o, '0);
        check("t4_rst_valid", pix_if.window_valid_o, 1'b0);
        check("t4_rst_done", pix_if.frame_done_o, 1'b0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        send_frame(0, W * H, 0, 1'b0);
        idle(4);

`ifdef SOF_CHECK_EN
        // T5: sof at pixel index 6 aborts and restarts
        send_frame(0, 6, 0, 1'b0);
        send_frame(50, W * H, 0, 1'b1);
        idle(4);

        // T6: pixels without sof in IDLE are ignored
        for (int k = 0; k < 5; k++) drive(PW'(200 + k), 1'b0, 1'b1);
        idle(3);
        send_frame(0, W * H, 30, 1'b0);
        idle(4);
`endif

        idle(4);
        check("sb_win_empty", win_q.size(), 0);
        check("sb_done_empty", done_q.size(), 0);
        check("sb_err_empty", err_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
